// File: rtl/apt_pkg.sv
// ============================================================================
// Module      : apt_pkg
// Description : Shared types and arithmetic helpers for adaptive_probability_table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apt_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    RESCALE = 2'd2,
    APPLY   = 2'd3
  } apt_state_e;

  // Halving never drops an entry to zero, so every symbol stays decodable.
  function automatic int unsigned halve_floor1(input int unsigned x);
    int unsigned h;
    h = x >> 1;
    return (h == 0) ? 32'd1 : h;
  endfunction

  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned fmax);
    int unsigned s;
    s = a + b;
    return (s > fmax) ? fmax : s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apt_row_sum.sv
// ============================================================================
// Module      : apt_row_sum
// Description : Combinational balanced adder tree over one packed frequency row.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apt_row_sum #(
  parameter int NUM_SYMBOLS = 16,
  parameter int PROB_WIDTH  = 8,
  parameter int TOT_W       = 12
) (
  input  logic [NUM_SYMBOLS*PROB_WIDTH-1:0] row,
  output logic [TOT_W-1:0]                  sum
);

  localparam int LEVELS = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 0;
  localparam int LEAVES = 1 << LEVELS;
  localparam int NODES  = 2 * LEAVES - 1;

  // Heap layout: node i has children 2i+1 and 2i+2; leaves padded with zero.
  logic [TOT_W-1:0] node [NODES];

  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      node[i] = '0;
    end
    for (int i = 0; i < NUM_SYMBOLS; i++) begin
      node[LEAVES-1+i] = TOT_W'(row[i*PROB_WIDTH +: PROB_WIDTH]);
    end
    for (int i = LEAVES - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    sum = node[0];
  end

endmodule

`default_nettype wire

// File: rtl/adaptive_probability_table.sv
// ============================================================================
// Module      : adaptive_probability_table
// Description : Context-indexed adaptive symbol-frequency table for the ANS
//               decoder. Optional feature macro: APT_OOR_FLAG_EN (oor_err).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adaptive_probability_table
  import apt_pkg::*;
#(
  parameter  int CONTEXT_WIDTH = 4,
  parameter  int PROB_WIDTH    = 8,
  parameter  int NUM_SYMBOLS   = 16,
  parameter  int NUM_CONTEXTS  = 16,
  parameter  int INIT_FREQ     = 1,
  parameter  int INC_STEP      = 16,
  localparam int SYM_W         = $clog2(NUM_SYMBOLS),
  localparam int TOT_W         = PROB_WIDTH + SYM_W
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            init_done,
  input  logic                            lk_valid,
  output logic                            lk_ready,
  input  logic [CONTEXT_WIDTH-1:0]        lk_context,
  output logic                            prob_valid,
  output logic [NUM_SYMBOLS*PROB_WIDTH-1:0] prob_distribution,
  output logic [TOT_W-1:0]                prob_total,
  input  logic                            upd_valid,
  output logic                            upd_ready,
  input  logic [CONTEXT_WIDTH-1:0]        upd_context,
  input  logic [SYM_W-1:0]                upd_symbol
`ifdef APT_OOR_FLAG_EN
  ,
  output logic                            oor_err
`endif
);

  localparam int FMAX  = (1 << PROB_WIDTH) - 1;
  localparam int ROW_W = NUM_SYMBOLS * PROB_WIDTH;

  localparam logic [1:0] S_INIT    = INIT;
  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_RESCALE = RESCALE;
  localparam logic [1:0] S_APPLY   = APPLY;

  localparam logic [CONTEXT_WIDTH:0]   NCTX      = (CONTEXT_WIDTH+1)'(NUM_CONTEXTS);
  localparam logic [SYM_W:0]           NSYM      = (SYM_W+1)'(NUM_SYMBOLS);
  localparam logic [CONTEXT_WIDTH-1:0] LAST_ROW  = CONTEXT_WIDTH'(NUM_CONTEXTS - 1);
  localparam logic [PROB_WIDTH-1:0]    INIT_WORD = PROB_WIDTH'(INIT_FREQ);
  localparam logic [PROB_WIDTH-1:0]    INC_WORD  = PROB_WIDTH'(INC_STEP);

  logic [1:0]               state;
  logic [CONTEXT_WIDTH-1:0] init_row;
  logic [CONTEXT_WIDTH-1:0] lat_ctx;
  logic [SYM_W-1:0]         lat_sym;
  logic [ROW_W-1:0]         mem [NUM_CONTEXTS];

  logic                     lk_fire;
  logic                     upd_fire;
  logic                     lk_ctx_ok;
  logic                     upd_ctx_ok;
  logic                     upd_sym_ok;
  logic                     upd_fits;
  logic [CONTEXT_WIDTH-1:0] lk_ctx;
  logic [CONTEXT_WIDTH-1:0] upd_ctx;
  logic [PROB_WIDTH-1:0]    upd_entry;
  logic [ROW_W-1:0]         lk_row;
  logic [TOT_W-1:0]         lk_sum;

  logic                     wr_en;
  logic [CONTEXT_WIDTH-1:0] wr_ctx;
  logic [ROW_W-1:0]         wr_row;

  assign lk_ready  = (state != S_INIT);
  assign upd_ready = (state == S_IDLE);
  assign lk_fire   = lk_valid & lk_ready;
  assign upd_fire  = upd_valid & upd_ready;

  // Out-of-range contexts alias onto context 0.
  assign lk_ctx_ok  = ({1'b0, lk_context} < NCTX);
  assign upd_ctx_ok = ({1'b0, upd_context} < NCTX);
  assign upd_sym_ok = ({1'b0, upd_symbol} < NSYM);
  assign lk_ctx     = lk_ctx_ok ? lk_context : '0;
  assign upd_ctx    = upd_ctx_ok ? upd_context : '0;

  assign lk_row    = mem[lk_ctx];
  assign upd_entry = mem[upd_ctx][int'(upd_symbol)*PROB_WIDTH +: PROB_WIDTH];
  assign upd_fits  = ((32'(upd_entry) + 32'(INC_STEP)) <= 32'(FMAX));

  apt_row_sum #(
    .NUM_SYMBOLS (NUM_SYMBOLS),
    .PROB_WIDTH  (PROB_WIDTH),
    .TOT_W       (TOT_W)
  ) u_row_sum (
    .row (lk_row),
    .sum (lk_sum)
  );

  // Single row-wide write port; every state selects which row and contents.
  always_comb begin
    wr_en  = 1'b0;
    wr_ctx = init_row;
    wr_row = mem[lat_ctx];
    case (state)
      S_INIT: begin
        wr_en  = 1'b1;
        wr_row = {NUM_SYMBOLS{INIT_WORD}};
      end
      S_IDLE: begin
        if (upd_fire && upd_sym_ok && upd_fits) begin
          wr_en  = 1'b1;
          wr_ctx = upd_ctx;
          wr_row = mem[upd_ctx];
          wr_row[int'(upd_symbol)*PROB_WIDTH +: PROB_WIDTH] = upd_entry + INC_WORD;
        end
      end
      S_RESCALE: begin
        wr_en  = 1'b1;
        wr_ctx = lat_ctx;
        for (int s = 0; s < NUM_SYMBOLS; s++) begin
          wr_row[s*PROB_WIDTH +: PROB_WIDTH] =
            PROB_WIDTH'(halve_floor1(32'(mem[lat_ctx][s*PROB_WIDTH +: PROB_WIDTH])));
        end
      end
      S_APPLY: begin
        wr_en  = 1'b1;
        wr_ctx = lat_ctx;
        wr_row[int'(lat_sym)*PROB_WIDTH +: PROB_WIDTH] =
          PROB_WIDTH'(sat_add(32'(mem[lat_ctx][int'(lat_sym)*PROB_WIDTH +: PROB_WIDTH]),
                              32'(INC_STEP), 32'(FMAX)));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ctx] <= wr_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      init_row  <= '0;
      init_done <= 1'b0;
      lat_ctx   <= '0;
      lat_sym   <= '0;
    end else begin
      case (state)
        S_INIT: begin
          init_row <= init_row + CONTEXT_WIDTH'(1);
          if (init_row == LAST_ROW) begin
            state     <= S_IDLE;
            init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (upd_fire && upd_sym_ok && !upd_fits) begin
            lat_ctx <= upd_ctx;
            lat_sym <= upd_symbol;
            state   <= S_RESCALE;
          end
        end
        S_RESCALE: state <= S_APPLY;
        S_APPLY:   state <= S_IDLE;
        default:   state <= S_INIT;
      endcase
    end
  end

  // Lookup data is captured at acceptance, before any same-edge table write.
  always_ff @(posedge clk) begin
    if (rst) begin
      prob_valid        <= 1'b0;
      prob_distribution <= '0;
      prob_total        <= '0;
    end else begin
      prob_valid <= lk_fire;
      if (lk_fire) begin
        prob_distribution <= lk_row;
        prob_total        <= lk_sum;
      end
    end
  end

`ifdef APT_OOR_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      oor_err <= 1'b0;
    end else if ((lk_fire && !lk_ctx_ok) ||
                 (upd_fire && (!upd_ctx_ok || !upd_sym_ok))) begin
      oor_err <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_adaptive_probability_table.sv
// ============================================================================
// Module      : tb_adaptive_probability_table
// Description : Self-checking bench with a cycle-level behavioural table model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adaptive_probability_table;

  localparam int CW   = 5;
  localparam int NS   = 16;
  localparam int NC   = 16;
  localparam int PW   = 8;
  localparam int FMAX = 255;
  localparam int STEP = 16;

  logic           clk;
  logic           rst;
  logic           init_done;
  logic           lk_valid;
  logic           lk_ready;
  logic [CW-1:0]  lk_context;
  logic           prob_valid;
  logic [127:0]   prob_distribution;
  logic [11:0]    prob_total;
  logic           upd_valid;
  logic           upd_ready;
  logic [CW-1:0]  upd_context;
  logic [3:0]     upd_symbol;
`ifdef APT_OOR_FLAG_EN
  logic           oor_err;
`endif

  adaptive_probability_table #(
    .CONTEXT_WIDTH (CW),
    .PROB_WIDTH    (PW),
    .NUM_SYMBOLS   (NS),
    .NUM_CONTEXTS  (NC),
    .INIT_FREQ     (1),
    .INC_STEP      (STEP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .init_done         (init_done),
    .lk_valid          (lk_valid),
    .lk_ready          (lk_ready),
    .lk_context        (lk_context),
    .prob_valid        (prob_valid),
    .prob_distribution (prob_distribution),
    .prob_total        (prob_total),
    .upd_valid         (upd_valid),
    .upd_ready         (upd_ready),
    .upd_context       (upd_context),
    .upd_symbol        (upd_symbol)
`ifdef APT_OOR_FLAG_EN
    ,
    .oor_err           (oor_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: visible table contents plus a pending-rescale countdown
  // (2 = halving happens at the end of this cycle, 1 = increment happens).
  int mdl [NC][NS];
  int pending = 0;
  int pc = 0;
  int ps = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rmap(input int c);
    return (c < NC) ? c : 0;
  endfunction

  function automatic logic [127:0] mrow(input int c);
    logic [127:0] r;
    for (int s = 0; s < NS; s++) r[s*PW +: PW] = 8'(mdl[c][s]);
    return r;
  endfunction

  function automatic int msum(input int c);
    int t = 0;
    for (int s = 0; s < NS; s++) t += mdl[c][s];
    return t;
  endfunction

  task automatic model_init();
    for (int c = 0; c < NC; c++)
      for (int s = 0; s < NS; s++) mdl[c][s] = 1;
    pending = 0;
  endtask

  // One clock cycle of traffic; called at #1 after an active edge.
  task automatic cyc(input bit dl, input int lc, input bit du, input int uc, input int us);
    logic [127:0] exp_row;
    int exp_tot;
    bit acc_up;
    int c;
    int e;
    lk_valid    = dl;
    lk_context  = lc[CW-1:0];
    upd_valid   = du;
    upd_context = uc[CW-1:0];
    upd_symbol  = us[3:0];
    chk("lk_ready", lk_ready, 1'b1);
    chk("upd_ready", upd_ready, pending == 0);
    exp_row = mrow(rmap(lc));
    exp_tot = msum(rmap(lc));
    acc_up  = du && (pending == 0);
    @(posedge clk); #1;
    lk_valid  = 1'b0;
    upd_valid = 1'b0;
    chk("prob_valid", prob_valid, dl);
    if (dl) begin
      chk("prob_distribution", prob_distribution, exp_row);
      chk("prob_total", prob_total, exp_tot);
    end
    if (pending == 2) begin
      for (int s = 0; s < NS; s++) mdl[pc][s] = (mdl[pc][s] / 2 < 1) ? 1 : mdl[pc][s] / 2;
      pending = 1;
    end else if (pending == 1) begin
      mdl[pc][ps] = (mdl[pc][ps] + STEP > FMAX) ? FMAX : mdl[pc][ps] + STEP;
      pending = 0;
    end else if (acc_up && us < NS) begin
      c = rmap(uc);
      e = mdl[c][us];
      if (e + STEP <= FMAX) mdl[c][us] = e + STEP;
      else begin
        pc = c;
        ps = us;
        pending = 2;
      end
    end
  endtask

  task automatic do_reset();
    int n;
    rst = 1'b1;
    lk_valid = 1'b0;
    upd_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_lk_ready", lk_ready, 1'b0);
    chk("rst_upd_ready", upd_ready, 1'b0);
    chk("rst_prob_valid", prob_valid, 1'b0);
    chk("rst_prob_dist", prob_distribution, 128'd0);
    chk("rst_prob_total", prob_total, 12'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_init();
    // Lookups requested during INIT must not be accepted.
    lk_valid = 1'b1;
    lk_context = 5'd3;
    n = 0;
    while (!init_done && n < 100) begin
      chk("init_lk_ready", lk_ready, 1'b0);
      @(posedge clk); #1;
      n++;
      if (!init_done) chk("init_prob_valid", prob_valid, 1'b0);
    end
    lk_valid = 1'b0;
    chk("init_cycles", n, 16);
  endtask

  initial begin
    rst = 1'b1;
    lk_valid = 1'b0;
    upd_valid = 1'b0;
    lk_context = '0;
    upd_context = '0;
    upd_symbol = '0;

    // Reset, INIT duration, and an initial all-ones row.
    do_reset();
    cyc(1, 9, 0, 0, 0);
    chk("init_row_value", prob_distribution, {16{8'h01}});
    chk("init_row_total", prob_total, 12'd16);
    cyc(1, 3, 0, 0, 0);

    // Fifteen plain increments, then an overflowing one with lookups
    // issued during RESCALE and APPLY.
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 3, 5);
    cyc(1, 3, 0, 0, 0);
    chk("ctx3_sym5_241", prob_distribution[47:40], 8'd241);
    cyc(0, 0, 1, 3, 5);
    chk("busy_upd_ready_rescale", upd_ready, 1'b0);
    cyc(1, 3, 0, 0, 0);
    chk("busy_upd_ready_apply", upd_ready, 1'b0);
    cyc(1, 3, 0, 0, 0);
    chk("halved_sym5_120", prob_distribution[47:40], 8'd120);
    cyc(1, 3, 0, 0, 0);
    chk("rescaled_sym5_136", prob_distribution[47:40], 8'd136);
    chk("rescaled_total_151", prob_total, 12'd151);
    chk("rescaled_sym0_1", prob_distribution[7:0], 8'd1);

    // Reset while RESCALE is in progress.
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 7, 2);
    cyc(0, 0, 1, 7, 2);
    chk("in_rescale", upd_ready, 1'b0);
    do_reset();
    cyc(1, 7, 0, 0, 0);
    chk("post_rst_ctx7", prob_distribution, {16{8'h01}});
    cyc(1, 3, 0, 0, 0);
    chk("post_rst_ctx3_total", prob_total, 12'd16);

    // Same-cycle lookup and update read the pre-update value.
`ifdef APT_OOR_FLAG_EN
    chk("oor_clear", oor_err, 1'b0);
`endif
    cyc(0, 0, 1, 3, 5);
    cyc(1, 3, 1, 3, 5);
    chk("rbw_17", prob_distribution[47:40], 8'd17);
    cyc(1, 3, 0, 0, 0);
    chk("after_rbw_33", prob_distribution[47:40], 8'd33);

    // Out-of-range contexts alias to context 0.
    cyc(1, 20, 0, 0, 0);
    chk("oor_lookup_total", prob_total, 12'd16);
`ifdef APT_OOR_FLAG_EN
    chk("oor_set", oor_err, 1'b1);
`endif
    cyc(0, 0, 1, 20, 1);
    cyc(1, 0, 0, 0, 0);
    chk("oor_update_ctx0_sym1", prob_distribution[15:8], 8'd17);

    // Randomised traffic concentrated on a few entries so rescales recur.
    for (int i = 0; i < 500; i++) begin
      int sel;
      int uc;
      sel = int'($urandom_range(0, 3));
      uc = (sel == 3) ? 20 : sel;
      cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
          $urandom_range(0, 3) != 0, uc, int'($urandom_range(0, 2)));
    end
`ifdef APT_OOR_FLAG_EN
    chk("oor_sticky", oor_err, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
